// File: rtl/packet_transmitter_if.sv
// Handshake and serial-line bundle for packet_transmitter.
// The master side (host or bench) drives the request and prices;
// the slave side (the transmitter) drives status and the TX line.
interface packet_transmitter_if;
  logic        send;
  logic [15:0] price_A;
  logic [15:0] price_B;
  logic        busy;
  logic        done;
  logic        uart_tx;

  modport master (
    output send,
    output price_A,
    output price_B,
    input  busy,
    input  done,
    input  uart_tx
  );

  modport slave (
    input  send,
    input  price_A,
    input  price_B,
    output busy,
    output done,
    output uart_tx
  );
endinterface

// File: rtl/packet_transmitter.sv
// Serializes one price packet (HEADER, price_A hi/lo, price_B hi/lo, FOOTER)
// onto an 8N1 UART line. Bytes are sent back to back with no idle gap, and
// the line can feed packet_parser's uart_rx directly.
module packet_transmitter #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter logic [7:0]  FOOTER       = 8'h55
) (
  input  logic                 clk,
  input  logic                 rst,
  packet_transmitter_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [31:0]      hold;
  logic             busy_q;
  logic             done_q;
  logic             tx_q;

  logic [7:0]       cur_byte;
  logic [2:0]       next_bit;
  logic             baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  // Select the byte being framed from the byte index and the latched prices.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    cur_byte = HEADER;
    next_bit = bit_idx + 3'd1;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = hold[31:24];
      3'd2:    cur_byte = hold[23:16];
      3'd3:    cur_byte = hold[15:8];
      3'd4:    cur_byte = hold[7:0];
      3'd5:    cur_byte = FOOTER;
      default: cur_byte = HEADER;
    endcase
  end

  // Framing FSM with counters and registered line/status outputs. The TX
  // value for each bit is loaded on the edge that starts the bit, so the
  // line is a clean flop output with no decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      hold     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // Registered busy gates acceptance, so a request on the edge where
          // a packet ends is dropped and the minimum idle gap is one cycle.
          if (bus.send && !busy_q) begin
            hold     <= {bus.price_A, bus.price_B};
            state    <= START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx_q     <= cur_byte[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx <= next_bit;
              tx_q    <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              state    <= IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              tx_q     <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx_q     <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.uart_tx = tx_q;

endmodule

// File: doc/packet_transmitter.md
# packet_transmitter

Serializes one price packet (header, price A, price B, footer) onto a UART TX line at 8N1. It is the transmit counterpart of `packet_parser` and uses the same framing, byte order and bit rate, so its output can drive `packet_parser`'s `uart_rx` directly. Within the arbitrage engine it returns price/test packets to the host and provides loopback stimulus for the parser.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per UART bit. The default gives 9600 baud at 50 MHz.
- `HEADER`, 8'hAA: first byte of every packet.
- `FOOTER`, 8'h55: last byte of every packet.

- `clk` input 1: system clock, 50 MHz nominal, rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `send` input 1: request to transmit one packet. Sampled on rising edges.
- `price_A` input 16: exchange A price in cents (unsigned), latched on accept.
- `price_B` input 16: exchange B price in cents (unsigned), latched on accept.
- `busy` output 1: high while a packet is in flight.
- `done` output 1: one-cycle pulse when the final stop bit completes.
- `uart_tx` output 1: serial line, registered, idles high.

## Operation
- **Packet bytes, in order:**
  - byte 0: `HEADER`
  - byte 1: `price_A[15:8]`
  - byte 2: `price_A[7:0]`
  - byte 3: `price_B[15:8]`
  - byte 4: `price_B[7:0]`
  - byte 5: `FOOTER`
- **Byte frame:** start bit 0, then data bits 0..7 (LSB first), then stop bit 1.
- **Byte spacing:** no idle gap between consecutive bytes. Each stop bit is followed immediately by the next start bit.
- **FSM states:**
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA stays for 8 bits, then → STOP.
  - STOP → START if byte index < 5.
  - STOP → IDLE if byte index == 5.
- **Counters:**
  - baud counter 0..CLKS_PER_BIT-1, wraps at the end of each bit
  - bit index 0..7
  - byte index 0..5
- **Accept rule:** `send` is accepted only on an edge where registered `busy`==0.
  - On accept, `price_A` and `price_B` are copied into an internal 32-bit holding register.
  - Input changes after accept have no effect on the current packet.
- **Ignored requests:** `send` while `busy`==1 is dropped. It is not queued.
- **Reset:** asserting `rst` at any time, including mid-bit, immediately forces:
  - `uart_tx`=1, `busy`=0, `done`=0
  - state IDLE, all counters 0
  - the partial packet is abandoned; no recovery frame is sent.
- **Reset values:** `uart_tx`=1, `busy`=0, `done`=0, holding register 0.

## Timing
- Let edge N be the edge where `send` is accepted.
  - At edge N: `uart_tx` becomes 0 (start of byte 0) and `busy` becomes 1.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- Byte k start bit begins at edge N + 10·k·CLKS_PER_BIT.
- Packet length is 60·CLKS_PER_BIT cycles. With the default this is 312480 cycles, about 6.25 ms.
- At edge N + 60·CLKS_PER_BIT:
  - `busy` falls to 0
  - `done` rises for exactly one cycle
  - `uart_tx` stays 1
- `send` on the edge where `busy` falls is ignored, because registered `busy` is still 1. The earliest next accept is edge N + 60·CLKS_PER_BIT + 1, so the minimum inter-packet idle is one cycle.
- `done` and `busy` are never high together.
- Edge case: `send` held continuously high produces packets separated by one idle cycle each.

## Test plan
- **Reset values:** hold `rst`=0 for 10 cycles → `uart_tx`=1, `busy`=0, `done`=0 throughout; `send`=1 during reset causes no transmission.
- **Single packet (CLKS_PER_BIT=16):** `price_A`=16'd4270 (0x10AE), `price_B`=16'd4235 (0x108B), pulse `send` → line decodes as AA 10 AE 10 8B 55. Check:
  - each start bit is 0 and each stop bit is 1, each exactly 16 cycles
  - `busy` high for 960 cycles
  - `done` pulses at edge N+960
- **Busy and input isolation:** mid-packet, change `price_A` to 0xFFFF and pulse `send` → transmitted bytes remain 10 AE; no second packet starts; `done` pulses once.
- **Reset mid-frame:** assert `rst` during bit 3 of byte 2 → `uart_tx`=1 asynchronously (before the next edge), `busy`=0, no `done`. A `send` after release produces a complete, correct packet.
- **Back-to-back:** keep `send`=1 across two packets → second start bit begins exactly 1 cycle after `done`; both packets decode correctly.
- **Loopback:** default CLKS_PER_BIT, `uart_tx` wired to `packet_parser.uart_rx` → `packet_valid` asserts with `price_A`=4270 and `price_B`=4235.
